instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//   Fetch/sequence unit that feeds the Controle decoder.
//   - Reads instruction words from a synchronous program ROM, holds them in an IR,
//     and presents opcode/operand to Controle.
//   - Consumes Controle's BranchZero/BranchEQ/MemRead/MemWrite to update the PC
//     and insert the data-memory wait cycle.
//   - Steps a fetch/load/execute FSM with one execute strobe per instruction.
// PARAMETERS
//   ADDR_W   4        PC / operand width; program space 2**ADDR_W words
//   INSTR_W  8        instruction width; IR[INSTR_W-1 -: 4]=opcode, IR[ADDR_W-1:0]=operand
//   HALT_OP  4'b1111  opcode that stops sequencing (not decoded by Controle)
// PORTS
//   clk         in   1        rising-edge clock
//   reset       in   1        synchronous, active-high
//   run         in   1        1 = allow new fetches; sampled in S_FETCH only
//   imem_rdata  in   INSTR_W  ROM data, valid the cycle after imem_rd_en
//   BranchZero  in   1        from Controle: unconditional jump (JMP)
//   BranchEQ    in   1        from Controle: jump if eq_flag
//   MemRead     in   1        from Controle: data-memory read this instruction
//   MemWrite    in   1        from Controle: data-memory write this instruction
//   eq_flag     in   1        ALU/compare equal flag, valid during exec_en
//   imem_addr   out  ADDR_W   ROM address (= pc)
//   imem_rd_en  out  1        ROM read strobe
//   opcode      out  4        IR opcode field -> Controle
//   operand     out  ADDR_W   IR operand field (address/immediate)
//   exec_en     out  1        1-cycle strobe: datapath commits Controle outputs
//   pc          out  ADDR_W   address of next instruction to fetch
//   halted      out  1        1 once HALT_OP executed
// BEHAVIOUR
//   Reset (sync, highest priority, any state, incl. mid-instruction):
//     - pc=0, IR=0 (opcode=0, operand=0), exec_en=0, imem_rd_en=0, halted=0, state=S_FETCH.
//     - In-flight instruction is discarded; no exec_en is issued for it.
//   FSM:
//     S_FETCH: if run: imem_rd_en=1, imem_addr=pc -> S_LOAD; else stay, imem_rd_en=0.
//     S_LOAD:  IR<=imem_rdata; pc<=pc+1 (mod 2**ADDR_W, 2**ADDR_W-1 wraps to 0) -> S_EXEC.
//     S_EXEC:  exec_en=1 for exactly this cycle; opcode/operand stable.
//       - opcode==HALT_OP: halted<=1 -> S_HALT; branch inputs ignored.
//       - else if BranchZero | (BranchEQ & eq_flag): pc<=operand (overrides the increment).
//       - next state: S_MEM if MemRead|MemWrite, else S_FETCH.
//     S_MEM:   one wait cycle, exec_en=0, IR held -> S_FETCH.
//     S_HALT:  imem_rd_en=0, exec_en=0, halted=1; left only by reset.
//   Timing:
//     - Non-memory instruction: 3 cycles. Memory instruction: 4 cycles.
//     - First exec_en after reset release with run=1: 3rd cycle.
//   Rules:
//     - opcode/operand change only on the S_LOAD edge; stable through S_EXEC/S_MEM
//       until the next S_LOAD.
//     - BranchZero and BranchEQ both asserted: one jump to operand.
//     - BranchEQ with eq_flag=0: no jump; pc keeps the incremented value.
//     - Branch to operand==pc: legal (tight loop).
//     - run deassert outside S_FETCH: the current instruction completes; the stall
//       happens at the next S_FETCH.
// TESTING
//   1. Reset, run=1, ROM[0]=0x03 (ADD): exec_en high cycle 3 only, opcode=0, operand=3, pc=1.
//   2. ROM[1]=0x25 (LDA 5), MemRead=1: exec_en on cycle 3 of that instr, S_MEM inserted,
//      next imem_rd_en 2 cycles after exec_en.
//   3. ROM[2]=0x79 (JMP 9), BranchZero=1: pc=9 after exec; next imem_addr=9.
//   4. BEQ 0xA4: eq_flag=0 -> pc=prev+1; eq_flag=1 -> pc=4. Both branch inputs high -> pc=4.
//   5. pc=15, non-branch instr: pc wraps to 0. Then ROM[0]=0xF0: halted=1, no further
//      imem_rd_en for 20 cycles.
//   6. Reset pulsed in S_LOAD and in S_MEM: next cycle pc=0, exec_en=0, halted=0,
//      fetch restarts at 0. Also run=0 in S_FETCH: imem_rd_en stays 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/load/execute sequencer feeding the Controle decoder: holds the
// instruction register, steps the program counter and paces execution.
module instr_sequencer #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned INSTR_W = 8,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               BranchZero,
  input  logic               BranchEQ,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               eq_flag,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  operand,
  output logic               exec_en,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  localparam int unsigned OP_W = 4;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic                halted_q, halted_d;

  logic [OP_W-1:0]     ir_opcode;
  logic [ADDR_W-1:0]   ir_operand;
  logic                is_halt;
  logic                take_branch;
  logic                mem_access;

  // Instruction fields and decoded control conditions
  assign ir_opcode   = ir_q[INSTR_W-1 -: OP_W];
  assign ir_operand  = ir_q[ADDR_W-1:0];
  assign is_halt     = (ir_opcode == HALT_OP);
  assign take_branch = BranchZero | (BranchEQ & eq_flag);
  assign mem_access  = MemRead | MemWrite;

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (mem_access) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State-decoded strobes: ROM read on a permitted fetch, one commit per instruction
  always_comb begin
    imem_rd_en = 1'b0;
    exec_en    = 1'b0;
    case (state_q)
      S_FETCH: imem_rd_en = run;
      S_EXEC:  exec_en    = 1'b1;
      default: begin
        imem_rd_en = 1'b0;
        exec_en    = 1'b0;
      end
    endcase
  end

  // Datapath next values: IR capture and increment on load, redirect or halt on execute
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    if (state_q == S_LOAD) begin
      ir_d = imem_rdata;
      pc_d = pc_q + ADDR_W'(1);
    end else if (state_q == S_EXEC) begin
      if (is_halt) begin
        halted_d = 1'b1;
      end else if (take_branch) begin
        pc_d = ir_operand;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Output wiring
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign opcode    = ir_opcode;
  assign operand   = ir_operand;
  assign halted    = halted_q;

  // Structural invariants of the sequencer
  a_exec_single : assert property (@(posedge clk) (!reset && exec_en) |=> !exec_en);
  a_halt_sticky : assert property (@(posedge clk) (!reset && halted) |=> halted);
  a_ir_stable   : assert property (@(posedge clk)
                    (!reset && state_q != S_LOAD) |=> $stable(ir_q));
  a_halt_quiet  : assert property (@(posedge clk)
                    (state_q == S_HALT) |-> (!imem_rd_en && !exec_en));

endmodule
